// File: rtl/mesm6_pic_pkg.sv
// mesm6_pic_pkg: register map and vector helper shared by the MESM-6 interrupt controller
package mesm6_pic_pkg;
  localparam logic [3:0] PIC_ACK    = 4'd0;
  localparam logic [3:0] PIC_EOI    = 4'd1;
  localparam logic [3:0] PIC_IECCLR = 4'd2;
  localparam logic [3:0] PIC_IECSET = 4'd3;
  localparam logic [3:0] PIC_IEC    = 4'd4;
  localparam logic [3:0] PIC_IFSCLR = 4'd5;
  localparam logic [3:0] PIC_IFSSET = 4'd6;
  localparam logic [3:0] PIC_IFS    = 4'd7;
  localparam logic [3:0] PIC_MODE   = 4'd8;
  localparam logic [3:0] PIC_ISR    = 4'd9;
  // Highest line maps to vector 1 so vector 0 can mean "nothing pending"
  function automatic int vec_of(input int index, input int nirq);
    return nirq - index;
  endfunction
endpackage

// File: rtl/mesm6_prio_enc.sv
// mesm6_prio_enc: index of the highest set bit of a vector
module mesm6_prio_enc #(
  parameter int N  = 48,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);
  // ascending scan so the highest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++)
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
  end
endmodule

// File: rtl/mesm6_vpic.sv
// mesm6_vpic: vectored, nesting interrupt controller on the MESM-6 peripheral bus
module mesm6_vpic
  import mesm6_pic_pkg::*;
#(
  parameter int NIRQ = 48,
  parameter int VW   = 6
) (
  input  logic            clk,
  input  logic            reset,
  output logic            interrupt,
  input  logic [NIRQ-1:0] pic_irq,
  input  logic [14:0]     pic_addr,
  input  logic            pic_read,
  input  logic            pic_write,
  input  logic [47:0]     pic_wdata,
  output logic [47:0]     pic_rdata,
  output logic            pic_done
);
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  logic [NIRQ-1:0] r_ifs, r_iec, r_isr, r_mode, r_irq_q;
  logic [47:0]     r_rdata;
  logic            r_done;
  logic [3:0]      w_a;
  logic [NIRQ-1:0] w_wd, w_above, w_elig, w_ack_bit, w_eoi_bit;
  logic [NIRQ-1:0] w_ifs_sw, w_ifs_nxt, w_iec_nxt, w_isr_nxt, w_mode_nxt;
  logic            w_isr_found, w_cl_found, w_wr, w_ack;
  logic [IW-1:0]   w_isr_idx, w_cl_idx;
  logic [VW-1:0]   w_vec;
  logic [47:0]     w_rd_mux;
  logic            w_unused;
  assign w_unused = ^{pic_addr[14:4], pic_wdata};
  assign w_a      = pic_addr[3:0];
  assign w_wd     = pic_wdata[NIRQ-1:0];
  assign w_wr     = pic_write;
  mesm6_prio_enc #(.N(NIRQ), .IW(IW)) u_isr_enc (.vec(r_isr),  .found(w_isr_found), .idx(w_isr_idx));
  mesm6_prio_enc #(.N(NIRQ), .IW(IW)) u_cl_enc  (.vec(w_elig), .found(w_cl_found),  .idx(w_cl_idx));
  // only lines strictly above the highest in-service line may preempt
  always_comb begin
    w_above = '0;
    for (int i = 0; i < NIRQ; i++) w_above[i] = !w_isr_found || (IW'(i) > w_isr_idx);
  end
  assign w_elig    = r_ifs & r_iec & ~r_isr & w_above;
  assign interrupt = |w_elig;
  assign w_vec     = w_cl_found ? VW'(vec_of(int'(w_cl_idx), NIRQ)) : '0;
  assign w_ack     = pic_read && (w_a == PIC_ACK) && w_cl_found;
  assign w_ack_bit = w_ack ? NIRQ'(1) << w_cl_idx : '0;
  assign w_eoi_bit = (w_wr && (w_a == PIC_EOI) && w_isr_found) ? NIRQ'(1) << w_isr_idx : '0;
  assign w_ifs_sw  = (w_wr && w_a == PIC_IFS)    ? w_wd :
                     (w_wr && w_a == PIC_IFSSET) ? r_ifs | w_wd :
                     (w_wr && w_a == PIC_IFSCLR) ? r_ifs & ~w_wd : r_ifs;
  // edge lines: software/ACK update, then a fresh rising edge overrides any clear
  assign w_ifs_nxt = (r_mode & ((w_ifs_sw & ~w_ack_bit) | (pic_irq & ~r_irq_q))) | (~r_mode & pic_irq);
  assign w_iec_nxt = (w_wr && w_a == PIC_IEC)    ? w_wd :
                     (w_wr && w_a == PIC_IECSET) ? r_iec | w_wd :
                     (w_wr && w_a == PIC_IECCLR) ? r_iec & ~w_wd : r_iec;
  assign w_mode_nxt = (w_wr && w_a == PIC_MODE) ? w_wd : r_mode;
  assign w_isr_nxt  = (r_isr | w_ack_bit) & ~w_eoi_bit;
  // read data is taken from pre-update state so a same-cycle write is not visible
  always_comb begin
    case (w_a)
      PIC_ACK:  w_rd_mux = 48'(w_vec);
      PIC_IEC:  w_rd_mux = 48'(r_iec);
      PIC_IFS:  w_rd_mux = 48'(r_ifs);
      PIC_MODE: w_rd_mux = 48'(r_mode);
      PIC_ISR:  w_rd_mux = 48'(r_isr);
      default:  w_rd_mux = '0;
    endcase
  end
  // register state; the claim side effects land together with the returned vector
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifs   <= '0;
      r_iec   <= '0;
      r_isr   <= '0;
      r_mode  <= '0;
      r_irq_q <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_ifs   <= w_ifs_nxt;
      r_iec   <= w_iec_nxt;
      r_isr   <= w_isr_nxt;
      r_mode  <= w_mode_nxt;
      r_irq_q <= pic_irq;
      r_rdata <= pic_read ? w_rd_mux : r_rdata;
      r_done  <= pic_read | pic_write;
    end
  end
  assign pic_rdata = r_rdata;
  assign pic_done  = r_done;
endmodule

// File: doc/mesm6_vpic.md
Name: mesm6_vpic

Overview:
Parametrised vectored interrupt controller for the MESM-6 core.
- Supports NIRQ request lines, each configurable as edge- or level-sensitive.
- Tracks in-service interrupts for nested preemption.
- Provides an acknowledge (claim) / end-of-interrupt handshake returning a priority vector.
- Sits on the CPU peripheral bus; drives the single interrupt request into the CPU.

Parameters:
- NIRQ, 48: number of request lines, 1..48. Bit NIRQ-1 is highest priority.
- VW, 6: vector width; must satisfy 2**VW > NIRQ.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- interrupt  out  1  request to CPU
- pic_irq  in  NIRQ  synchronised device requests
- pic_addr  in  15  register address; only [3:0] decoded
- pic_read  in  1  read strobe, one cycle
- pic_write  in  1  write strobe, one cycle
- pic_wdata  in  48  write data; bits above NIRQ ignored
- pic_rdata  out  48  read data, valid while pic_done=1
- pic_done  out  1  operation complete, one-cycle pulse

Behaviour:
- Register map, selected by addr[3:0]:
  - 0 ACK (read-only, claim)
  - 1 EOI (write-only, data ignored)
  - 2 IECCLR, 3 IECSET, 4 IEC
  - 5 IFSCLR, 6 IFSSET, 7 IFS
  - 8 MODE (read/write; 1 = edge, 0 = level)
  - 9 ISR (read-only)
  - 10..15 read 0; writes are ignored.
- Reset values: IFS, IEC, ISR, MODE and irq_q are all 0; pic_done=0; pic_rdata=0.
- irq_q is pic_irq registered every cycle.
- Edge line i:
  - IFS[i] is set on pic_irq[i] & ~irq_q[i].
  - It is cleared by IFSCLR or by ACK of vector NIRQ-i.
  - IFS/IFSSET writes modify it.
- Level line i:
  - IFS[i] <= pic_irq[i] every cycle.
  - Software writes and ACK do not modify it.
- Same-cycle set and clear on an edge line: set wins.
- Mode change takes effect next cycle. Its irq_q history is kept, so switching level to edge with the line held high generates no edge.
- IEC writes follow SET/CLR/direct semantics. Only bits [NIRQ-1:0] are stored.
- Priority calculation:
  - top_isr = highest set ISR bit index, or -1 if ISR is empty.
  - eligible = IFS & IEC & ~ISR, restricted to bits with index > top_isr.
  - interrupt = |eligible, computed combinationally from registers.
- Vector: for highest eligible bit k, vector = NIRQ-k (range 1..NIRQ). With no eligible bit, vector = 0.
- ACK read in cycle T:
  - pic_rdata = {zero, vector} and pic_done=1 in cycle T+1.
  - If vector != 0: ISR[k] is set at T+1, and IFS[k] is cleared if the line is edge mode.
  - If vector = 0: no state change.
- EOI write: clears ISR[top_isr]. With ISR empty it is a no-op. The done pulse is still given.
- All reads: data is sampled at the strobe cycle and registered, so pic_rdata is presented with pic_done at T+1. pic_rdata holds its value until the next read.
- pic_done <= pic_read | pic_write. Back-to-back strobes every cycle are legal.
- Read and write strobes in the same cycle: the write takes effect, and rdata returns the pre-write value.
- Reset asserted mid-access: pic_done is 0 next cycle, and any pending ACK side effect is discarded.
- Nesting: a higher-priority line arriving while a lower one is in service reasserts interrupt. Equal or lower priority lines are masked until EOI.

Decomposition:
- Package mesm6_pic_pkg:
  - Register address constants PIC_ACK .. PIC_ISR.
  - Function vec_of(index, NIRQ).
- Sub-module mesm6_prio_enc, parameter N, inputs vec[N-1:0], outputs found and idx.
  - Instantiated twice: once for eligible (claim) and once for ISR (top_isr).

Test Plan:
- Reset, MODE=all-level, IEC=all ones, pic_irq[47] high:
  - interrupt=1.
  - ACK returns 1 and ISR=bit47.
  - Drop irq, EOI: ISR=0, interrupt=0.
- Edge line 3, single-cycle pulse, IEC[3]=1:
  - IFS[3]=1, which persists after the pulse.
  - ACK returns 45; IFS[3]=0 and ISR[3]=1.
  - A second ACK returns 0.
- Nesting: line 5 in service, then pulse edge line 20:
  - interrupt=1; ACK returns 28; ISR = bits 20 and 5.
  - EOI clears bit 20 only.
  - Pulse line 2 while bit 5 is still in service: interrupt stays 0.
- Edge line 7: IFSCLR write with bit 7 in the same cycle as a rising edge on irq[7] -> IFS[7]=1 (set wins).
- IECSET 0x30, IECCLR 0x10, read IEC -> 0x20. Read addr 12 -> 0. Each access gives a single pic_done pulse one cycle after its strobe.
- NIRQ=8 build:
  - IFSSET 0xFF..FF -> IFS reads 0xFF.
  - ACK returns 1, and vectors cover 1..8.
  - Assert reset mid-ACK -> pic_done=0 and ISR=0.
